// File: rtl/fmt_pkg.sv
// rtl/fmt_pkg.sv - shared ASCII constants, mode codes and FSM states for the byte formatter
package fmt_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_1    = 8'h31;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EOL  = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit value to ASCII hex digit
module nibble_to_ascii
    import fmt_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       uppercase_i,
    output logic [7:0] char_o
);

    logic [7:0] letter_base;

    assign letter_base = uppercase_i ? ASCII_UC_A : ASCII_LC_A;

    always_comb begin
        char_o = ASCII_0 + {4'h0, nibble_i};
        if (nibble_i >= 4'd10) begin
            char_o = letter_base + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/byte_ascii_formatter.sv
// rtl/byte_ascii_formatter.sv - serialises stream bytes into hex or binary ASCII lines ending in LF
module byte_ascii_formatter
    import fmt_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0,
    parameter bit DROP_LF   = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_char,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             mode_q, mode_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       take_byte;
    logic [2:0] last_idx;
    logic [3:0] nibble;
    logic [7:0] hex_char;

    assign in_ready   = (state_q == IDLE) || ((state_q == EOL) && out_ready);
    assign accept     = in_valid && in_ready;
    // A dropped LF is still handshaked; it just never reaches EMIT.
    assign take_byte  = accept && !(DROP_LF && (in_data == ASCII_LF));
    assign last_idx   = (mode_q == MODE_BIN) ? 3'd7 : 3'd1;
    assign nibble     = idx_q[0] ? byte_q[3:0] : byte_q[7:4];
    assign busy       = (state_q != IDLE);
    assign byte_count = cnt_q;

    nibble_to_ascii u_nibble (
        .nibble_i    (nibble),
        .uppercase_i (UPPERCASE),
        .char_o      (hex_char)
    );

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_char  = 8'h00;

        case (state_q)
            IDLE: begin
                if (take_byte) begin
                    byte_d  = in_data;
                    mode_d  = mode;
                    idx_d   = 3'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (mode_q == MODE_BIN) begin
                    out_char = byte_q[3'd7 - idx_q] ? ASCII_1 : ASCII_0;
                end else begin
                    out_char = hex_char;
                end
                if (out_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = EOL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            EOL: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                    if (take_byte) begin
                        byte_d  = in_data;
                        mode_d  = mode;
                        idx_d   = 3'd0;
                        state_d = EMIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= 8'h00;
            mode_q  <= 1'b0;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
